// File: rtl/cim_weight_reader.sv
// Read-back sequencer for the CIM weight store: sweeps a row range of one core with STDR
// reads and streams the captured rows, tagged with their row number, over valid/ready.
module cim_weight_reader #(
    parameter int ROW_W      = 6,
    parameter int CORE_W     = 3,
    parameter int DATA_W     = 288,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CORE_W-1:0] core_sel,
    input  logic [ROW_W-1:0]  row_start,
    input  logic [ROW_W:0]    row_count,
    input  logic              stdw_active,
    input  logic [DATA_W-1:0] weight_out,
    output logic [CORE_W-1:0] STD_Core_A,
    output logic              STDR,
    output logic [ROW_W-1:0]  STD_row_A,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ROW_W-1:0]  rd_row,
    output logic              busy,
    output logic              done
);
    // RD_LAT spare slots absorb the reads still landing after the consumer stalls, so the
    // issue credit can count FIFO space freed by this cycle's pop and still stream at 1 row/cycle.
    localparam int BUF_DEPTH = FIFO_DEPTH + RD_LAT;
    localparam int PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam logic [ROW_W:0] MAX_ROWS = (ROW_W + 1)'(1 << ROW_W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [CORE_W-1:0]       core_q, core_d;
    logic [ROW_W-1:0]        row_a_q, row_a_d;
    logic [ROW_W-1:0]        next_row_q, next_row_d;
    logic [ROW_W:0]          remaining_q, remaining_d;
    logic                    stdr_q, stdr_d;
    logic                    done_q, done_d;
    logic [RD_LAT:1]         vld_pipe_q, vld_pipe_d;
    logic [RD_LAT:1][ROW_W-1:0] tag_pipe_q, tag_pipe_d;
    logic [DATA_W-1:0]       mem_q [BUF_DEPTH];
    logic [DATA_W-1:0]       mem_d [BUF_DEPTH];
    logic [ROW_W-1:0]        tag_mem_q [BUF_DEPTH];
    logic [ROW_W-1:0]        tag_mem_d [BUF_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        fifo_cnt_q, fifo_cnt_d;

    logic           push, pop, issue, idle_pipe;
    logic [ROW_W:0] clamped;
    int             pend;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        clamped = (row_count > MAX_ROWS) ? MAX_ROWS : row_count;
        push    = vld_pipe_q[RD_LAT];
        pop     = (fifo_cnt_q != '0) && rd_ready;
        // Reads whose data has not yet reached weight_out.
        pend    = int'(stdr_q);
        for (int k = 1; k < RD_LAT; k++) pend += int'(vld_pipe_q[k]);
        issue   = (state_q == S_RUN) && !stdw_active && (remaining_q != '0) &&
                  (pend + int'(fifo_cnt_q) < FIFO_DEPTH + int'(pop));
        idle_pipe = !stdr_q && (vld_pipe_q == '0);

        state_d     = state_q;
        core_d      = core_q;
        row_a_d     = row_a_q;
        next_row_d  = next_row_q;
        remaining_d = remaining_q;
        stdr_d      = issue;
        done_d      = 1'b0;

        if (issue) begin
            row_a_d     = next_row_q;
            next_row_d  = next_row_q + ROW_W'(1);
            remaining_d = remaining_q - (ROW_W + 1)'(1);
        end

        case (state_q)
            S_IDLE: if (start) begin
                core_d      = core_sel;
                next_row_d  = row_start;
                remaining_d = clamped;
                state_d     = (clamped == '0) ? S_DONE : S_RUN;
            end
            S_RUN:   if (issue && remaining_q == (ROW_W + 1)'(1)) state_d = S_DRAIN;
            S_DRAIN: if (idle_pipe && fifo_cnt_q == '0) state_d = S_DONE;
            default: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        endcase

        vld_pipe_d    = vld_pipe_q;
        tag_pipe_d    = tag_pipe_q;
        vld_pipe_d[1] = stdr_q;
        tag_pipe_d[1] = row_a_q;
        for (int k = 2; k <= RD_LAT; k++) begin
            vld_pipe_d[k] = vld_pipe_q[k-1];
            tag_pipe_d[k] = tag_pipe_q[k-1];
        end

        mem_d      = mem_q;
        tag_mem_d  = tag_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            mem_d[wr_ptr_q]     = weight_out;
            tag_mem_d[wr_ptr_q] = tag_pipe_q[RD_LAT];
            wr_ptr_d            = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            core_q      <= '0;
            row_a_q     <= '0;
            next_row_q  <= '0;
            remaining_q <= '0;
            stdr_q      <= 1'b0;
            done_q      <= 1'b0;
            vld_pipe_q  <= '0;
            tag_pipe_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i]     <= '0;
                tag_mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            core_q      <= core_d;
            row_a_q     <= row_a_d;
            next_row_q  <= next_row_d;
            remaining_q <= remaining_d;
            stdr_q      <= stdr_d;
            done_q      <= done_d;
            vld_pipe_q  <= vld_pipe_d;
            tag_pipe_q  <= tag_pipe_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            mem_q       <= mem_d;
            tag_mem_q   <= tag_mem_d;
        end
    end

    // done is registered off the DONE state so it rises in the same cycle busy falls.
    assign STD_Core_A = core_q;
    assign STDR       = stdr_q;
    assign STD_row_A  = row_a_q;
    assign rd_valid   = (fifo_cnt_q != '0);
    assign rd_data    = mem_q[rd_ptr_q];
    assign rd_row     = tag_mem_q[rd_ptr_q];
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
endmodule

// File: tb/tb_cim_weight_reader.sv
// Directed bench for cim_weight_reader: command table plus reset/abort sequence, with a
// behavioural CIM store that returns weight_out one cycle after a registered STDR.
module tb_cim_weight_reader;
    logic         clk = 1'b0;
    logic         rst, start, stdw_active, rd_ready;
    logic [2:0]   core_sel;
    logic [5:0]   row_start;
    logic [6:0]   row_count;
    logic [287:0] weight_out;
    logic [2:0]   STD_Core_A;
    logic         STDR, rd_valid, busy, done;
    logic [5:0]   STD_row_A, rd_row;
    logic [287:0] rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    cim_weight_reader dut (
        .clk(clk), .rst(rst), .start(start), .core_sel(core_sel), .row_start(row_start),
        .row_count(row_count), .stdw_active(stdw_active), .weight_out(weight_out),
        .STD_Core_A(STD_Core_A), .STDR(STDR), .STD_row_A(STD_row_A), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_data(rd_data), .rd_row(rd_row), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Core 4 is pre-loaded with all 4'b0001; other cores hold a core/row signature.
    function automatic logic [287:0] pat(input logic [2:0] c, input logic [5:0] r);
        logic [35:0] w;
        if (c == 3'd4) return {72{4'h1}};
        w = {1'b0, c, 2'b00, r, 24'hC0FFEE};
        return {8{w}};
    endfunction

    always @(posedge clk) if (STDR) weight_out <= pat(STD_Core_A, STD_row_A);

    task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] core;
        logic [5:0] rs;
        logic [6:0] rc;
        bit         stall;
        int         stdw_at;
        int         exp_n;
    } vec_t;

    task automatic run_cmd(input vec_t v);
        int cyc = 0, issued = 0, beats = 0, done_cnt = 0, done_cyc = -1;
        int first_stdr = -1, last_stdr = -1, first_beat = -1, stall_left = 10;
        bit prev_stdw = 0, hold = 0, tog = 0;
        logic [287:0] held_data = '0;
        logic [5:0]   held_row = '0, er;
        @(negedge clk);
        core_sel = v.core; row_start = v.rs; row_count = v.rc; start = 1'b1; rd_ready = 1'b1;
        while (cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (cyc == 1) chk("busy_after_start", busy, 1);
            if (prev_stdw) chk("stdr_paused", STDR, 0);
            if (STDR) begin
                er = v.rs + 6'(issued);
                chk("stdr_row", STD_row_A, er);
                chk("stdr_core", STD_Core_A, v.core);
                if (first_stdr < 0) first_stdr = cyc;
                last_stdr = cyc;
                issued++;
            end
            if (hold) begin
                chk("stall_valid", rd_valid, 1);
                chk("stall_data", rd_data, held_data);
                chk("stall_row", rd_row, held_row);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_with_done", busy, 0);
            end
            stdw_active = (v.stdw_at != 0) && (cyc >= v.stdw_at) && (cyc < v.stdw_at + 5);
            prev_stdw   = stdw_active;
            if (v.stdw_at != 0 && cyc == 6) begin
                start = 1'b1; core_sel = 3'd0; row_start = 6'd0; row_count = 7'd5;
            end
            if (v.stdw_at != 0 && cyc == 7) start = 1'b0;
            if (v.stall && beats >= 1) begin
                if (stall_left > 0) begin
                    rd_ready = 1'b0;
                    stall_left--;
                end else begin
                    tog = ~tog;
                    rd_ready = tog;
                end
            end else rd_ready = 1'b1;
            if (rd_valid && rd_ready) begin
                er = v.rs + 6'(beats);
                chk("beat_row", rd_row, er);
                chk("beat_data", rd_data, pat(v.core, er));
                if (beats == 0) first_beat = cyc;
                beats++;
            end
            hold      = rd_valid && !rd_ready;
            held_data = rd_data;
            held_row  = rd_row;
            if (done_cnt > 0 && cyc >= done_cyc + 3) break;
        end
        rd_ready = 1'b1;
        chk("done_count", done_cnt, 1);
        chk("issue_count", issued, v.exp_n);
        chk("beat_count", beats, v.exp_n);
        chk("busy_end", busy, 0);
        if (v.exp_n == 0) chk("zero_done_cycle", done_cyc, 2);
        if (v.exp_n > 0 && !v.stall) chk("first_beat_cycle", first_beat, 4);
        if (v.exp_n > 0 && !v.stall && v.stdw_at == 0) begin
            chk("first_stdr_cycle", first_stdr, 2);
            chk("stdr_back_to_back", last_stdr - first_stdr + 1, v.exp_n);
        end
    endtask

    vec_t vecs[7];
    vec_t post;

    initial begin
        int beats;
        vecs[0] = '{3'd4, 6'd35, 7'd1,   1'b0, 0, 1};
        vecs[1] = '{3'd3, 6'd0,  7'd64,  1'b0, 0, 64};
        vecs[2] = '{3'd2, 6'd60, 7'd8,   1'b0, 0, 8};
        vecs[3] = '{3'd5, 6'd10, 7'd100, 1'b0, 0, 64};
        vecs[4] = '{3'd1, 6'd7,  7'd0,   1'b0, 0, 0};
        vecs[5] = '{3'd6, 6'd20, 7'd32,  1'b1, 0, 32};
        vecs[6] = '{3'd7, 6'd5,  7'd20,  1'b0, 8, 20};
        post    = '{3'd2, 6'd50, 7'd4,   1'b0, 0, 4};

        rst = 1'b1; start = 1'b0; stdw_active = 1'b0; rd_ready = 1'b1;
        core_sel = '0; row_start = '0; row_count = '0; weight_out = '0;
        repeat (3) @(negedge clk);
        chk("rst_stdr", STDR, 0);
        chk("rst_row_a", STD_row_A, 0);
        chk("rst_core_a", STD_Core_A, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_row", rd_row, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

        // Abort a 64-row sweep after 10 beats.
        @(negedge clk);
        core_sel = 3'd3; row_start = 6'd0; row_count = 7'd64; start = 1'b1; rd_ready = 1'b1;
        beats = 0;
        for (int c = 0; c < 100 && beats < 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (rd_valid && rd_ready) beats++;
        end
        chk("abort_beats_seen", beats, 10);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_stdr", STDR, 0);
        chk("abort_row_a", STD_row_A, 0);
        chk("abort_core_a", STD_Core_A, 0);
        chk("abort_valid", rd_valid, 0);
        chk("abort_data", rd_data, 0);
        chk("abort_row", rd_row, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        rst = 1'b0;
        beats = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done || STDR || rd_valid) beats++;
        end
        chk("abort_quiet", beats, 0);
        run_cmd(post);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
